ccw_sequencer: RTL and testbench

// Upstream stage of channel: queues channel command words (CCWs), issues each to channel via

---
 rtl/ccw_sequencer.sv | 157 +++++++++++++++
 tb/tb_ccw_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ccw_sequencer.sv
// rtl/ccw_sequencer.sv - CCW queue and channel program sequencer with command chaining, status evaluation and timeout
module ccw_sequencer #(
  parameter int          DEPTH          = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ERROR_MASK     = 8'h13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] s_ccw_tdata,
  input  logic        s_ccw_tvalid,
  output logic        s_ccw_tready,
  input  logic [7:0]  prog_address,
  input  logic        prog_start,
  output logic        prog_busy,
  output logic        prog_done,
  output logic [7:0]  prog_status,
  output logic [7:0]  prog_res_count,
  output logic [2:0]  prog_error,
  output logic [3:0]  prog_ccw_count,
  output logic [7:0]  address,
  output logic [7:0]  command,
  output logic [7:0]  count,
  output logic        start_strobe,
  input  logic        channel_done,
  input  logic [7:0]  channel_status,
  input  logic [7:0]  channel_res_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_EVAL     = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;
  localparam logic [2:0] S_COMPLETE = 3'd5;

  logic [2:0]    state;
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ, occ_next;
  logic          push, pop, empty;
  logic [17:0]   head;
  logic          cc, sli;
  logic [TW-1:0] timer;
  logic [2:0]    eval_code;
  logic          unused_flags;

  // Only CC and SLI of the flag byte affect sequencing.
  assign unused_flags = ^s_ccw_tdata[23:18];

  assign head      = mem[rd_ptr];
  assign empty     = (occ == '0);
  assign push      = s_ccw_tvalid && s_ccw_tready;
  assign pop       = ((state == S_ISSUE) || (state == S_FLUSH)) && !empty;
  assign occ_next  = occ + (AW+1)'(push) - (AW+1)'(pop);
  assign prog_busy = (state != S_IDLE);
  assign prog_done = (state == S_COMPLETE);

  always_comb begin
    eval_code = 3'd0;
    if ((prog_status & ERROR_MASK) != 8'd0)
      eval_code = 3'd1;
    else if ((prog_res_count != 8'd0) && !sli)
      eval_code = 3'd2;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_ccw_tdata[17:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      s_ccw_tready   <= 1'b1;
      prog_status    <= 8'd0;
      prog_res_count <= 8'd0;
      prog_error     <= 3'd0;
      prog_ccw_count <= 4'd0;
      address        <= 8'd0;
      command        <= 8'd0;
      count          <= 8'd0;
      start_strobe   <= 1'b0;
      cc             <= 1'b0;
      sli            <= 1'b0;
      timer          <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ          <= occ_next;
      s_ccw_tready <= (occ_next != (AW+1)'(DEPTH));
      start_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (prog_start) begin
            address        <= prog_address;
            prog_ccw_count <= 4'd0;
            prog_error     <= 3'd0;
            if (empty) begin
              prog_error <= 3'd3;
              state      <= S_COMPLETE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          command      <= head[15:8];
          count        <= head[7:0];
          cc           <= head[16];
          sli          <= head[17];
          start_strobe <= 1'b1;
          if (prog_ccw_count != 4'd15) prog_ccw_count <= prog_ccw_count + 4'd1;
          timer        <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (channel_done) begin
            prog_status    <= channel_status;
            prog_res_count <= channel_res_count;
            state          <= S_EVAL;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            prog_error <= 3'd4;
            state      <= S_COMPLETE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_EVAL: begin
          if (eval_code != 3'd0) begin
            prog_error <= eval_code;
            state      <= cc ? S_FLUSH : S_COMPLETE;
          end else if (cc) begin
            if (empty) begin
              prog_error <= 3'd3;
              state      <= S_COMPLETE;
            end else begin
              state <= S_ISSUE;
            end
          end else begin
            state <= S_COMPLETE;
          end
        end
        // Drop the rest of a failed chain: stop after the first CC=0 entry.
        S_FLUSH: begin
          if (empty || !head[16]) state <= S_COMPLETE;
        end
        S_COMPLETE: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccw_sequencer.sv
// tb/tb_ccw_sequencer.sv - directed self-checking bench for ccw_sequencer
module tb_ccw_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] s_ccw_tdata;
  logic        s_ccw_tvalid;
  logic        s_ccw_tready;
  logic [7:0]  prog_address;
  logic        prog_start;
  logic        prog_busy, prog_done;
  logic [7:0]  prog_status, prog_res_count;
  logic [2:0]  prog_error;
  logic [3:0]  prog_ccw_count;
  logic [7:0]  address, command, count;
  logic        start_strobe;
  logic        channel_done;
  logic [7:0]  channel_status, channel_res_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] resp_st [4];
  logic [7:0] resp_rs [4];
  bit         respond;
  int         strobes, done_cyc;
  int         strobe_cyc [4];
  logic       busy_first;

  always #5 clk = ~clk;

  ccw_sequencer dut (
    .clk(clk), .reset(reset),
    .s_ccw_tdata(s_ccw_tdata), .s_ccw_tvalid(s_ccw_tvalid), .s_ccw_tready(s_ccw_tready),
    .prog_address(prog_address), .prog_start(prog_start),
    .prog_busy(prog_busy), .prog_done(prog_done),
    .prog_status(prog_status), .prog_res_count(prog_res_count),
    .prog_error(prog_error), .prog_ccw_count(prog_ccw_count),
    .address(address), .command(command), .count(count), .start_strobe(start_strobe),
    .channel_done(channel_done), .channel_status(channel_status),
    .channel_res_count(channel_res_count)
  );

  task automatic push_ccw(input logic [7:0] flags, input logic [7:0] cmd, input logic [7:0] cnt);
    s_ccw_tdata  = {flags, cmd, cnt};
    s_ccw_tvalid = 1'b1;
    @(negedge clk);
    s_ccw_tvalid = 1'b0;
  endtask

  // Channel responder: answers each start_strobe with channel_done on the following edge.
  task automatic run_prog();
    strobes  = 0;
    done_cyc = 0;
    prog_address = 8'h5A;
    prog_start = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
    busy_first = prog_busy;
    for (int c = 1; c <= 2000; c++) begin
      channel_done = 1'b0;
      if (start_strobe) begin
        if (strobes < 4) begin
          strobe_cyc[strobes] = c;
          channel_status      = resp_st[strobes];
          channel_res_count   = resp_rs[strobes];
        end
        channel_done = respond;
        strobes++;
      end
      if (prog_done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    channel_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (s_ccw_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %0b exp 1", s_ccw_tready); end
    checks++; if ({prog_busy, prog_done, start_strobe} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {prog_busy, prog_done, start_strobe}); end
    checks++; if ({prog_error, prog_ccw_count, address, command, count} !== 31'd0) begin errors++; $display("FAIL reset_regs got %0h exp 0", {prog_error, prog_ccw_count, address, command, count}); end
  endtask

  task automatic test_single(input logic [7:0] flags, input logic [2:0] exp_err);
    push_ccw(flags, 8'h02, 8'h10);
    resp_st[0] = 8'h0C; resp_rs[0] = 8'd10; respond = 1'b1;
    run_prog();
    checks++; if (strobes !== 1) begin errors++; $display("FAIL single_strobes got %0d exp 1", strobes); end
    checks++; if (strobe_cyc[0] !== 2) begin errors++; $display("FAIL single_start_latency got %0d exp 2", strobe_cyc[0]); end
    checks++; if (done_cyc !== 4) begin errors++; $display("FAIL single_done_cycle got %0d exp 4", done_cyc); end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy_first); end
    checks++; if (prog_error !== exp_err) begin errors++; $display("FAIL single_error got %0d exp %0d", prog_error, exp_err); end
    checks++; if ({prog_status, prog_res_count} !== 16'h0C0A) begin errors++; $display("FAIL single_status_res got %h exp 0c0a", {prog_status, prog_res_count}); end
    checks++; if ({address, command, count} !== 24'h5A0210) begin errors++; $display("FAIL single_channel_regs got %h exp 5a0210", {address, command, count}); end
    checks++; if ({prog_busy, prog_done} !== 2'b00) begin errors++; $display("FAIL single_idle_after got %b exp 00", {prog_busy, prog_done}); end
  endtask

  task automatic test_empty();
    respond = 1'b1;
    run_prog();
    checks++; if (strobes !== 0) begin errors++; $display("FAIL empty_strobes got %0d exp 0", strobes); end
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL empty_done_cycle got %0d exp 1", done_cyc); end
    checks++; if ({prog_error, prog_ccw_count} !== {3'd3, 4'd0}) begin errors++; $display("FAIL empty_error_count got %0d/%0d exp 3/0", prog_error, prog_ccw_count); end
  endtask

  task automatic test_chain();
    push_ccw(8'h01, 8'h02, 8'h04);
    push_ccw(8'h01, 8'h03, 8'h05);
    push_ccw(8'h00, 8'h04, 8'h06);
    for (int i = 0; i < 3; i++) begin resp_st[i] = 8'h0C; resp_rs[i] = 8'd0; end
    respond = 1'b1;
    run_prog();
    checks++; if (strobes !== 3) begin errors++; $display("FAIL chain_strobes got %0d exp 3", strobes); end
    checks++; if (strobe_cyc[1] - strobe_cyc[0] !== 3) begin errors++; $display("FAIL chain_spacing got %0d exp 3", strobe_cyc[1] - strobe_cyc[0]); end
    checks++; if ({prog_error, prog_ccw_count} !== {3'd0, 4'd3}) begin errors++; $display("FAIL chain_error_count got %0d/%0d exp 0/3", prog_error, prog_ccw_count); end
    checks++; if ({command, count} !== 16'h0406) begin errors++; $display("FAIL chain_last_ccw got %h exp 0406", {command, count}); end
    test_empty();
  endtask

  task automatic test_chain_error();
    push_ccw(8'h01, 8'h02, 8'h04);
    push_ccw(8'h01, 8'h03, 8'h05);
    push_ccw(8'h00, 8'h04, 8'h06);
    push_ccw(8'h00, 8'h08, 8'h20);
    resp_st[0] = 8'h0C; resp_rs[0] = 8'd0;
    resp_st[1] = 8'h0E; resp_rs[1] = 8'd0;
    respond = 1'b1;
    run_prog();
    checks++; if (strobes !== 2) begin errors++; $display("FAIL chainerr_strobes got %0d exp 2", strobes); end
    checks++; if ({prog_error, prog_ccw_count, prog_status} !== {3'd1, 4'd2, 8'h0E}) begin errors++; $display("FAIL chainerr_result got %0d/%0d/%h exp 1/2/0e", prog_error, prog_ccw_count, prog_status); end
    resp_st[0] = 8'h0C; resp_rs[0] = 8'd0;
    run_prog();
    checks++; if (strobes !== 1) begin errors++; $display("FAIL survivor_strobes got %0d exp 1", strobes); end
    checks++; if ({prog_error, command, count} !== {3'd0, 8'h08, 8'h20}) begin errors++; $display("FAIL survivor_ccw got %0d/%h/%h exp 0/08/20", prog_error, command, count); end
    test_empty();
  endtask

  task automatic test_timeout();
    push_ccw(8'h02, 8'h02, 8'h10);
    respond = 1'b0;
    run_prog();
    checks++; if (strobes !== 1) begin errors++; $display("FAIL timeout_strobes got %0d exp 1", strobes); end
    checks++; if (done_cyc !== 2 + 1024) begin errors++; $display("FAIL timeout_done_cycle got %0d exp 1026", done_cyc); end
    checks++; if (prog_error !== 3'd4) begin errors++; $display("FAIL timeout_error got %0d exp 4", prog_error); end
  endtask

  task automatic test_full_and_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (s_ccw_tready !== 1'b1) begin errors++; $display("FAIL fill_tready_%0d got %0b exp 1", i, s_ccw_tready); end
      push_ccw(8'h02, 8'(8'h40 + i), 8'h01);
    end
    checks++; if (s_ccw_tready !== 1'b0) begin errors++; $display("FAIL full_tready got %0b exp 0", s_ccw_tready); end
    prog_address = 8'h33;
    prog_start = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
    @(negedge clk);
    checks++; if ({start_strobe, command} !== {1'b1, 8'h40}) begin errors++; $display("FAIL midreset_issue got %b/%h exp 1/40", start_strobe, command); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({prog_busy, prog_done, start_strobe, s_ccw_tready} !== 4'b0001) begin errors++; $display("FAIL midreset_flags got %b exp 0001", {prog_busy, prog_done, start_strobe, s_ccw_tready}); end
    checks++; if ({address, command, count, prog_ccw_count} !== 28'd0) begin errors++; $display("FAIL midreset_regs got %h exp 0", {address, command, count, prog_ccw_count}); end
    @(negedge clk);
    checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got %0b exp 0", prog_done); end
    test_empty();
  endtask

  initial begin
    reset = 1'b1;
    s_ccw_tdata = '0; s_ccw_tvalid = 1'b0;
    prog_address = '0; prog_start = 1'b0;
    channel_done = 1'b0; channel_status = '0; channel_res_count = '0;
    respond = 1'b1;
    @(negedge clk);
    test_reset();
    test_single(8'h02, 3'd0);
    test_single(8'h00, 3'd2);
    test_chain();
    test_chain_error();
    test_empty();
    test_timeout();
    test_full_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
